barry_motion: RTL and testbench
===============================

// Module: barry_motion
// PURPOSE
//  Parametrised vertical-motion engine for the player sprite. Signed velocity with
//  gravity/thrust acceleration, velocity saturation and screen-bound clamping, all
//  updated on a divided physics tick. Feeds y0 to the sprite renderer and state and
//  landed to game logic. Adds pause (freeze) support.
// PARAMETERS
//  Y_W        9    position width (screen pixels, y grows downward)
//  V_W        5    signed velocity width
//  Y_MIN      4    ceiling clamp position
//  Y_MAX      470  floor clamp position
//  RESET_Y    469  position after reset
//  TICK_DIV   256  clk cycles per physics tick (>=2)
//  GRAVITY    1    downward accel per tick when thrust=0
//  THRUST     2    upward accel per tick when thrust=1
//  VMAX_UP    3    max upward speed (vel >= -VMAX_UP)
//  VMAX_DOWN  4    max downward speed (vel <= VMAX_DOWN)
// PORTS
//  clk     in   1    system clock
//  reset   in   1    asynchronous, active-high reset
//  thrust  in   1    jetpack button, level; sampled only on tick cycles
//  freeze  in   1    pause: holds divider and all state while high
//  y0      out  Y_W  top-left y of sprite
//  vel     out  V_W  signed velocity, px/tick (negative = up)
//  state   out  2    motion_state_t {GROUNDED, CEILING, RISING, FALLING}
//  tick    out  1    one-cycle pulse on each physics update
//  landed  out  1    one-cycle pulse when entering GROUNDED from airborne
// BEHAVIOUR
//  Reset (async): y0=RESET_Y, vel=0, divider=0, tick=0, landed=0, state=FALLING.
//  Divider: counts 0..TICK_DIV-1 when freeze=0; update occurs on the cycle it equals
//   TICK_DIV-1, then wraps to 0. freeze=1 holds the count (freeze beats tick).
//   First update falls TICK_DIV cycles after reset release.
//  Update (one clk, registered; outputs valid the cycle after the count hits
//  TICK_DIV-1; tick asserts in that same cycle):
//   1. v' = thrust ? max(vel-THRUST, -VMAX_UP) : min(vel+GRAVITY, VMAX_DOWN)
//   2. y' = y0 + v', computed signed in Y_W+2 bits (no wrap)
//   3. y' <= Y_MIN -> y0=Y_MIN, vel=0; y' >= Y_MAX -> y0=Y_MAX, vel=0;
//      otherwise y0=y', vel=v'.
//  state (combinational from registers, priority order): y0==Y_MAX -> GROUNDED;
//   y0==Y_MIN -> CEILING; vel<0 -> RISING; else FALLING (includes vel==0 midair).
//  landed: high one cycle when the update moves y0 to Y_MAX and the previous y0 != Y_MAX.
//   Resting on the floor with thrust=0 re-clamps with no landed pulse.
//  Thrust changes between ticks have no effect; only the tick-cycle value counts.
//  Reset mid-flight: outputs return to reset values immediately, with no clock needed.
//  Intermediate v' width V_W+1; parameters are constrained so that
//  VMAX_UP/VMAX_DOWN fit V_W signed.
// STRUCTURE
//  barry_pkg: motion_state_t enum, default physics constants.
//  Sub-module tick_gen #(TICK_DIV): divider with enable (=~freeze) and a tick pulse.
//  barry_motion: velocity/position registers, clamp logic, state decode, landed edge.
// TESTING
//  1 Reset, hold 10 clk -> y0=469, vel=0, state=FALLING, tick=0, landed=0.
//  2 thrust=0, run 256 clk -> tick, y0=470, vel=0, landed 1 clk, GROUNDED; next
//    tick: no landed, y0 stays 470.
//  3 From floor, hold thrust -> ticks give (vel,y0) = (-2,468), (-3,465), (-3,462)
//    (saturated), state=RISING.
//  4 Hold thrust to ceiling -> y0=4, vel=0, CEILING; release -> vel=1, y0=5, FALLING.
//  5 freeze=1 for 100 clk mid-count -> y0/vel/state hold, next tick 100 clk late.
//  6 Assert reset between clk edges while RISING -> y0=469, vel=0 before next edge.

Source files
------------

// File: rtl/barry_pkg.sv
// barry_pkg: shared types and default physics constants for the player
// vertical-motion engine.
//   motion_state_t : coarse motion classification fed to game logic
//   DEF_*          : default parameter values for barry_motion and its interface
package barry_pkg;

  typedef enum logic [1:0] {
    GROUNDED = 2'd0,
    CEILING  = 2'd1,
    RISING   = 2'd2,
    FALLING  = 2'd3
  } motion_state_t;

  localparam int DEF_Y_W       = 9;
  localparam int DEF_V_W       = 5;
  localparam int DEF_Y_MIN     = 4;
  localparam int DEF_Y_MAX     = 470;
  localparam int DEF_RESET_Y   = 469;
  localparam int DEF_TICK_DIV  = 256;
  localparam int DEF_GRAVITY   = 1;
  localparam int DEF_THRUST    = 2;
  localparam int DEF_VMAX_UP   = 3;
  localparam int DEF_VMAX_DOWN = 4;

endpackage

// File: rtl/barry_motion_if.sv
// barry_motion_if: control inputs and motion outputs of the vertical-motion engine.
//   thrust  : jetpack button (level)
//   freeze  : pause, holds divider and all motion state
//   y0      : sprite top-left y
//   vel     : signed velocity, px/tick (negative = up)
//   state   : motion_state_t classification
//   tick    : one-cycle pulse per physics update
//   landed  : one-cycle pulse on entering GROUNDED from airborne
// master = game/control side, slave = motion engine.
interface barry_motion_if
  import barry_pkg::*;
#(
  parameter int Y_W = DEF_Y_W,
  parameter int V_W = DEF_V_W
);
  logic                  thrust;
  logic                  freeze;
  logic [Y_W-1:0]        y0;
  logic signed [V_W-1:0] vel;
  motion_state_t         state;
  logic                  tick;
  logic                  landed;

  modport master (
    output thrust, freeze,
    input  y0, vel, state, tick, landed
  );

  modport slave (
    input  thrust, freeze,
    output y0, vel, state, tick, landed
  );
endinterface

// File: rtl/barry_motion_tick_gen.sv
// tick_gen: physics-tick divider.
//   clk    : system clock
//   rst    : asynchronous active-high reset
//   en     : count enable (low holds the count)
//   update : combinational strobe, high on the enabled cycle where the count
//            equals TICK_DIV-1 (the count wraps to 0 on that edge)
module tick_gen #(
  parameter int TICK_DIV = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic update
);
  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] count;
  logic          at_end;

  assign at_end = (count == CW'(TICK_DIV - 1));
  assign update = en & at_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= at_end ? '0 : count + 1'b1;
    end
  end
endmodule

// File: rtl/barry_motion.sv
// barry_motion: vertical-motion engine for the player sprite.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : barry_motion_if.slave (thrust/freeze in; y0/vel/state/tick/landed out)
// On each physics tick velocity is accelerated (gravity or thrust), saturated,
// added to the position, and the position clamped to [Y_MIN, Y_MAX] with
// velocity zeroed at either bound.
module barry_motion
  import barry_pkg::*;
#(
  parameter int Y_W       = DEF_Y_W,
  parameter int V_W       = DEF_V_W,
  parameter int Y_MIN     = DEF_Y_MIN,
  parameter int Y_MAX     = DEF_Y_MAX,
  parameter int RESET_Y   = DEF_RESET_Y,
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int GRAVITY   = DEF_GRAVITY,
  parameter int THRUST    = DEF_THRUST,
  parameter int VMAX_UP   = DEF_VMAX_UP,
  parameter int VMAX_DOWN = DEF_VMAX_DOWN
) (
  input logic          clk,
  input logic          reset,
  barry_motion_if.slave bus
);
  localparam int VX = V_W + 1;
  localparam int YX = Y_W + 2;

  localparam logic signed [VX-1:0] THR_X  = VX'(THRUST);
  localparam logic signed [VX-1:0] GRV_X  = VX'(GRAVITY);
  localparam logic signed [VX-1:0] VUP_X  = VX'(-VMAX_UP);
  localparam logic signed [VX-1:0] VDN_X  = VX'(VMAX_DOWN);
  localparam logic signed [YX-1:0] YMIN_X = YX'(Y_MIN);
  localparam logic signed [YX-1:0] YMAX_X = YX'(Y_MAX);
  localparam logic [Y_W-1:0]       YMIN_P = Y_W'(Y_MIN);
  localparam logic [Y_W-1:0]       YMAX_P = Y_W'(Y_MAX);

  logic [Y_W-1:0]        y_q;
  logic signed [V_W-1:0] v_q;
  logic                  tick_q;
  logic                  landed_q;

  logic                  en;
  logic                  update;
  logic signed [VX-1:0]  v_ext;
  logic signed [VX-1:0]  v_try;
  logic signed [VX-1:0]  v_next;
  logic signed [YX-1:0]  y_sum;
  logic [Y_W-1:0]        y_new;
  logic signed [V_W-1:0] v_new;
  motion_state_t         state;

  assign en = ~bus.freeze;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk    (clk),
    .rst    (reset),
    .en     (en),
    .update (update)
  );

  // Acceleration and saturation are evaluated one bit wider than vel so the
  // pre-saturation value cannot wrap; the position sum is two bits wider than
  // y0 so both overshoot directions compare correctly against the bounds.
  always_comb begin
    v_ext  = {v_q[V_W-1], v_q};
    v_try  = '0;
    v_next = '0;
    if (bus.thrust) begin
      v_try  = v_ext - THR_X;
      v_next = (v_try < VUP_X) ? VUP_X : v_try;
    end else begin
      v_try  = v_ext + GRV_X;
      v_next = (v_try > VDN_X) ? VDN_X : v_try;
    end
    y_sum = $signed({2'b00, y_q}) + YX'(v_next);
    if (y_sum <= YMIN_X) begin
      y_new = YMIN_P;
      v_new = '0;
    end else if (y_sum >= YMAX_X) begin
      y_new = YMAX_P;
      v_new = '0;
    end else begin
      y_new = y_sum[Y_W-1:0];
      v_new = v_next[V_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_q      <= Y_W'(RESET_Y);
      v_q      <= '0;
      tick_q   <= 1'b0;
      landed_q <= 1'b0;
    end else begin
      tick_q   <= update;
      landed_q <= update && (y_new == YMAX_P) && (y_q != YMAX_P);
      if (update) begin
        y_q <= y_new;
        v_q <= v_new;
      end
    end
  end

  always_comb begin
    if (y_q == YMAX_P)      state = GROUNDED;
    else if (y_q == YMIN_P) state = CEILING;
    else if (v_q < 0)       state = RISING;
    else                    state = FALLING;
  end

  assign bus.y0     = y_q;
  assign bus.vel    = v_q;
  assign bus.state  = state;
  assign bus.tick   = tick_q;
  assign bus.landed = landed_q;
endmodule

// File: tb/tb_barry_motion.sv
// tb_barry_motion: scoreboard bench for barry_motion with default parameters.
module tb_barry_motion;
  import barry_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  barry_motion_if #(.Y_W(9), .V_W(5)) bus ();

  barry_motion #(
    .Y_W(9), .V_W(5), .Y_MIN(4), .Y_MAX(470), .RESET_Y(469), .TICK_DIV(256),
    .GRAVITY(1), .THRUST(2), .VMAX_UP(3), .VMAX_DOWN(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int edge_no;
    int y;
    int v;
    int st;
    bit landed;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   vectors     = 0;
  int   miscompares = 0;
  int   edges       = 0;
  int   m_y, m_v, m_cnt;

  task automatic check(input string tag, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int model_state(input int y, input int v);
    if (y == 470) return int'(GROUNDED);
    if (y == 4)   return int'(CEILING);
    if (v < 0)    return int'(RISING);
    return int'(FALLING);
  endfunction

  // Reference update, pushed when the tick-cycle thrust value is driven
  task automatic model_update(input bit th);
    int   nv, ny, old_y;
    exp_t x;
    old_y = m_y;
    if (th) nv = (m_v - 2 < -3) ? -3 : m_v - 2;
    else    nv = (m_v + 1 > 4) ? 4 : m_v + 1;
    ny = m_y + nv;
    if (ny <= 4)        begin m_y = 4;   m_v = 0;  end
    else if (ny >= 470) begin m_y = 470; m_v = 0;  end
    else                begin m_y = ny;  m_v = nv; end
    x.edge_no = edges + 1;
    x.y       = m_y;
    x.v       = m_v;
    x.st      = model_state(m_y, m_v);
    x.landed  = (m_y == 470) && (old_y != 470);
    q.push_back(x);
  endtask

  task automatic model_reset();
    m_y   = 469;
    m_v   = 0;
    m_cnt = 0;
    q.delete();
  endtask

  task automatic cycle(input bit th, input bit fr, input bit rs);
    @(negedge clk);
    bus.thrust = th;
    bus.freeze = fr;
    reset      = rs;
    if (rs) begin
      model_reset();
    end else if (!fr) begin
      if (m_cnt == 255) model_update(th);
      m_cnt = (m_cnt + 1) % 256;
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_now(input string tag, input int y, input int v, input int st);
    check({tag, "_y0"},    int'(bus.y0), y);
    check({tag, "_vel"},   int'($signed(bus.vel)), v);
    check({tag, "_state"}, int'(bus.state), st);
  endtask

  always @(posedge clk) edges <= edges + 1;

  always @(negedge clk) begin
    if (bus.tick) begin
      if (q.size() == 0) begin
        check("spurious_tick", 1, 0);
      end else begin
        e = q.pop_front();
        check("tick_time", edges, e.edge_no);
        check("sb_y0", int'(bus.y0), e.y);
        check("sb_vel", int'($signed(bus.vel)), e.v);
        check("sb_state", int'(bus.state), e.st);
        check("sb_landed", int'(bus.landed), int'(e.landed));
      end
    end else begin
      check("landed_idle", int'(bus.landed), 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct { int v; int y; } vy_t;
  vy_t rise_tbl[3] = '{'{-2, 468}, '{-3, 465}, '{-3, 462}};

  initial begin
    reset      = 1'b1;
    bus.thrust = 1'b0;
    bus.freeze = 1'b0;
    model_reset();

    // Reset hold
    repeat (10) cycle(0, 0, 1);
    settle();
    check_now("reset", 469, 0, int'(FALLING));
    check("reset_tick", int'(bus.tick), 0);
    check("reset_landed", int'(bus.landed), 0);

    // First tick lands on the floor
    repeat (256) cycle(0, 0, 0);
    settle();
    check_now("land", 470, 0, int'(GROUNDED));
    check("land_tick", int'(bus.tick), 1);
    check("land_landed", int'(bus.landed), 1);

    // Resting re-clamp: no landed pulse
    repeat (256) cycle(0, 0, 0);
    settle();
    check_now("rest", 470, 0, int'(GROUNDED));
    check("rest_tick", int'(bus.tick), 1);
    check("rest_landed", int'(bus.landed), 0);

    // Thrust from the floor with upward saturation
    for (int i = 0; i < 3; i++) begin
      repeat (256) cycle(1, 0, 0);
      settle();
      check_now("rise", rise_tbl[i].y, rise_tbl[i].v, int'(RISING));
    end

    // Thrust to the ceiling (bounded)
    for (int i = 0; i < 200 && m_y != 4; i++) begin
      repeat (256) cycle(1, 0, 0);
    end
    settle();
    check_now("ceiling", 4, 0, int'(CEILING));

    // Release thrust off the ceiling
    repeat (256) cycle(0, 0, 0);
    settle();
    check_now("release", 5, 1, int'(FALLING));

    // Freeze mid-count for 100 cycles; tick slips by 100
    repeat (100) cycle(0, 0, 0);
    repeat (100) cycle(0, 1, 0);
    settle();
    check_now("frozen", 5, 1, int'(FALLING));
    check("frozen_tick", int'(bus.tick), 0);
    repeat (156) cycle(0, 0, 0);
    settle();
    check("thaw_tick", int'(bus.tick), 1);
    check_now("thaw", 7, 2, int'(FALLING));

    // Fall then thrust until rising mid-air
    repeat (5) repeat (256) cycle(0, 0, 0);
    repeat (3) repeat (256) cycle(1, 0, 0);
    settle();
    check_now("midair", 26, -2, int'(RISING));

    // Asynchronous reset between edges
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_now("async_rst", 469, 0, int'(FALLING));
    check("async_rst_tick", int'(bus.tick), 0);
    model_reset();
    repeat (3) cycle(0, 0, 1);

    // Divider restarts from zero after release
    repeat (255) cycle(0, 0, 0);
    settle();
    check("pre_tick", int'(bus.tick), 0);
    check_now("pre", 469, 0, int'(FALLING));
    cycle(0, 0, 0);
    settle();
    check("post_rst_tick", int'(bus.tick), 1);
    check_now("post_rst", 470, 0, int'(GROUNDED));

    repeat (5) cycle(0, 0, 0);
    check("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
